// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// The master side is the pipeline (operands, op, readout select); the slave
// side is the unit (busy/stall status and the HI/LO readout).
interface mult_div_unit_if;
    logic        En;
    logic [2:0]  MDOp;
    logic [31:0] RS_Data;
    logic [31:0] RT_Data;
    logic        RdSel;
    logic        Busy;
    logic        Stall_Req;
    logic [31:0] Out;

    modport master (
        output En, MDOp, RS_Data, RT_Data, RdSel,
        input  Busy, Stall_Req, Out
    );

    modport slave (
        input  En, MDOp, RS_Data, RT_Data, RdSel,
        output Busy, Stall_Req, Out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed from operands latched on the accept edge and land in
// HI/LO on the edge where the latency down-counter reaches zero.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no op in flight; En/MDOp accepted, MTHI/MTLO write at once
//   S_BUSY | mult/div in flight; counter runs down, requests ignored
module mult_div_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic           CLK,
    input logic           Reset,
    mult_div_unit_if.slave md
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    // HI/LO start at zero in simulation so Out is never X before reset.
    logic [31:0]      hi_q = '0;
    logic [31:0]      lo_q = '0;
    logic [31:0]      hi_d, lo_d;

    logic             busy;
    logic             is_md_op;

    logic signed [63:0] sa, sb;
    logic [63:0]        prod_s, prod_u;
    logic               a_neg, b_neg, div_by_zero;
    logic [31:0]        mag_a, mag_b, dvs, uq, ur, quo, rem;

    assign busy         = (state_q == S_BUSY);
    assign is_md_op     = (md.MDOp >= OP_MULT) && (md.MDOp <= OP_DIVU);
    assign md.Busy      = busy;
    assign md.Stall_Req = busy | (md.En & is_md_op);
    assign md.Out       = md.RdSel ? hi_q : lo_q;

    // Result datapath on latched operands; one unsigned divider serves both
    // DIV and DIVU by dividing magnitudes and fixing signs afterwards, which
    // also makes 0x80000000 / -1 come out as 0x80000000 rem 0 naturally.
    always_comb begin
        sa          = {{32{a_q[31]}}, a_q};
        sb          = {{32{b_q[31]}}, b_q};
        prod_s      = sa * sb;
        prod_u      = {32'b0, a_q} * {32'b0, b_q};
        a_neg       = (op_q == OP_DIV) & a_q[31];
        b_neg       = (op_q == OP_DIV) & b_q[31];
        mag_a       = a_neg ? (~a_q + 32'd1) : a_q;
        mag_b       = b_neg ? (~b_q + 32'd1) : b_q;
        div_by_zero = (b_q == 32'd0);
        dvs         = div_by_zero ? 32'd1 : mag_b;
        uq          = mag_a / dvs;
        ur          = mag_a % dvs;
        quo         = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem         = a_neg ? (32'd0 - ur) : ur;
    end

    // Accept/countdown/complete control and HI/LO next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == S_IDLE) begin
            if (md.En) begin
                case (md.MDOp)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        a_d     = md.RS_Data;
                        b_d     = md.RT_Data;
                        op_d    = md.MDOp;
                        cnt_d   = ((md.MDOp == OP_MULT) || (md.MDOp == OP_MULTU))
                                  ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                        state_d = S_BUSY;
                    end
                    OP_MTHI: hi_d = md.RS_Data;
                    OP_MTLO: lo_d = md.RS_Data;
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_IDLE;
                case (op_q)
                    OP_MULT:  {hi_d, lo_d} = prod_s;
                    OP_MULTU: {hi_d, lo_d} = prod_u;
                    OP_DIV, OP_DIVU: begin
                        if (!div_by_zero) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers; reset wins over any accept or completion.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.
- Consumes the two GRF read operands (RD1 → RS_Data, RD2 → RT_Data).
- Its Out value returns to the register-file write-data path for MFHI/MFLO.
- Models fixed multi-cycle latency. The hazard unit stalls dependent HI/LO instructions while Busy is high.

Parameters:
- MULT_LAT, 5, cycles Busy stays high for MULT/MULTU (≥1)
- DIV_LAT, 10, cycles Busy stays high for DIV/DIVU (≥1)

Ports:
- CLK  input  1  clock, all state changes on posedge
- Reset  input  1  synchronous, active-high reset
- En  input  1  operation request qualifier for MDOp
- MDOp  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- RS_Data  input  32  operand A / MTHI-MTLO source (from GRF RD1)
- RT_Data  input  32  operand B (from GRF RD2)
- RdSel  input  1  0 selects LO, 1 selects HI on Out
- Busy  output  1  registered; high while a mult/div is in flight
- Stall_Req  output  1  combinational: Busy | (En & MDOp∈{1..4})
- Out  output  32  combinational: RdSel ? HI : LO

Behaviour:
- Reset: already decided — reset Reset, synchronous, active-high; clock CLK.
  - On a posedge with Reset=1: HI=0, LO=0, Busy=0, counter=0, pending op discarded.
  - Reset has priority over every other event, including an in-flight operation (result dropped, HI/LO stay 0).
- Accept rule: an operation is accepted at a posedge only when Reset=0, En=1 and Busy=0.
  - While Busy=1, any En/MDOp is ignored, including MTHI/MTLO. The hazard unit must hold the instruction.
- MTHI/MTLO: on the accept edge, HI (or LO) ← RS_Data. There is no Busy cycle, and the new value is visible on Out the next cycle.
- MULT/MULTU/DIV/DIVU accept edge:
  - latch RS_Data, RT_Data and the op into internal registers;
  - load counter = MULT_LAT or DIV_LAT;
  - set Busy=1.
- In flight: the counter decrements each posedge. HI/LO keep their old values, and Out reflects the old values throughout.
- Completion:
  - On the posedge where the counter goes 1→0, write HI/LO and set Busy=0, in the same edge.
  - Busy is therefore high for exactly LAT cycles after the accept edge.
  - A new op may be accepted at the first posedge where Busy=0 (back-to-back gap = LAT cycles).
- Arithmetic, on the latched operands:
  - MULT: {HI,LO} = signed(A)×signed(B), full 64-bit.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = A/B, HI = A%B, unsigned.
- Boundary cases:
  - B=0 for DIV/DIVU: full latency and Busy profile still occur, but HI and LO are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No exception.
- Operand stability: RS_Data/RT_Data changes after the accept edge must not affect the result.
- Stall_Req:
  - high in the accept cycle itself (En & mult/div op) as well as during Busy;
  - low for MTHI/MTLO/NONE when Busy=0.
- No X on any output after the first reset edge. HI/LO are also initialised to 0 at time zero for simulation.

Test Plan:
- MULT vs MULTU: RS=0xFFFFFFFF, RT=0x00000002.
  - MULT → after 5 Busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU → HI=0x00000001, LO=0xFFFFFFFE.
- DIV vs DIVU: RS=0xFFFFFFF9 (−7), RT=2.
  - DIV → Busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
- Divide by zero and overflow:
  - MTHI 0x12345678, MTLO 0x9ABCDEF0, then DIV by 0 → Busy 10 cycles, HI/LO unchanged.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Busy interlock:
  - Start MULT, then assert En with MTLO 0xDEADBEEF on cycle 2 of Busy → ignored; LO = product at completion.
  - Repeat MTLO after Busy falls → LO=0xDEADBEEF next cycle.
  - Check Stall_Req=1 in the accept cycle and all Busy cycles.
- Operand stability and readout:
  - Change RS/RT every cycle during a MULTU of 0x10000×0x10000 → HI=0x00000001, LO=0.
  - Out toggles HI/LO with RdSel and shows old values while Busy.
- Reset mid-operation:
  - Assert Reset on Busy cycle 3 of a DIV → next cycle Busy=0, HI=LO=0, and no later write occurs.
  - Reset with En=1/MTHI on the same edge → HI=0.
